// File: rtl/in_controlador.sv
// CPU input port: synchronises switches/button, debounces the button and stalls the
// CPU until one fresh press delivers a switch sample on saida (valido pulses once).
module in_controlador #(
  parameter int WIDTH           = 18,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] switch,
  input  logic             botao,
  input  logic             escreveInput,
  output logic             haltIn,
  output logic [WIDTH-1:0] saida,
  output logic             valido
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    OCIOSO,
    ESPERA_SOLTAR,
    ESPERA_PRESS,
    ENTREGA
  } estado_t;

  estado_t                              estado_q, estado_d;
  logic [SYNC_STAGES-1:0]               b_sync_q, b_sync_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0]    sw_sync_q, sw_sync_d;
  logic                                 estavel_q, estavel_d;
  logic [CW-1:0]                        contador_q, contador_d;
  logic [WIDTH-1:0]                     saida_q, saida_d;
  logic                                 valido_q, valido_d;
  logic                                 b_s;
  logic [WIDTH-1:0]                     sw_s;

  assign b_s  = b_sync_q[SYNC_STAGES-1];
  assign sw_s = sw_sync_q[SYNC_STAGES-1];

  always_comb begin
    b_sync_d  = {b_sync_q[SYNC_STAGES-2:0], botao};
    sw_sync_d = {sw_sync_q[SYNC_STAGES-2:0], switch};
  end

  // Accept a new button level only after it differs from the accepted one for
  // DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
  always_comb begin
    estavel_d  = estavel_q;
    contador_d = contador_q;
    if (b_s == estavel_q) begin
      contador_d = '0;
    end else if (contador_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      estavel_d  = b_s;
      contador_d = '0;
    end else begin
      contador_d = contador_q + CW'(1);
    end
  end

  always_comb begin
    estado_d = estado_q;
    saida_d  = saida_q;
    valido_d = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (escreveInput) estado_d = estavel_q ? ESPERA_SOLTAR : ESPERA_PRESS;
      end
      ESPERA_SOLTAR: begin
        if (!escreveInput)   estado_d = OCIOSO;
        else if (!estavel_q) estado_d = ESPERA_PRESS;
      end
      ESPERA_PRESS: begin
        // A dropped request wins over a press seen on the same edge.
        if (!escreveInput) begin
          estado_d = OCIOSO;
        end else if (estavel_q) begin
          estado_d = ENTREGA;
          saida_d  = sw_s;
          valido_d = 1'b1;
        end
      end
      ENTREGA: estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q   <= OCIOSO;
      b_sync_q   <= '0;
      sw_sync_q  <= '0;
      estavel_q  <= 1'b0;
      contador_q <= '0;
      saida_q    <= '0;
      valido_q   <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      b_sync_q   <= b_sync_d;
      sw_sync_q  <= sw_sync_d;
      estavel_q  <= estavel_d;
      contador_q <= contador_d;
      saida_q    <= saida_d;
      valido_q   <= valido_d;
    end
  end

  assign haltIn = reset_n & escreveInput & (estado_q != ENTREGA);
  assign saida  = saida_q;
  assign valido = valido_q;

endmodule

// File: tb/tb_in_controlador.sv
// Bench for in_controlador: directed scenarios plus random traffic, all checked against
// a sample-history reference model of the input port.
module tb_in_controlador;

  localparam int W    = 18;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int HMAX = 8192;

  logic         clock = 1'b0;
  logic         reset_n = 1'b1;
  logic [W-1:0] switch = '0;
  logic         botao = 1'b0;
  logic         escreveInput = 1'b0;
  logic         haltIn;
  logic [W-1:0] saida;
  logic         valido;

  int n_cmp = 0;
  int n_bad = 0;
  int n_deliv = 0;

  in_controlador #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
    .clock(clock), .reset_n(reset_n), .switch(switch), .botao(botao),
    .escreveInput(escreveInput), .haltIn(haltIn), .saida(saida), .valido(valido)
  );

  always #5 clock = ~clock;

  // Reference model: raw input history per edge since reset, button level accepted
  // once the last DEB synchronised samples all disagree with the accepted level.
  int           k = 0;
  logic         bin  [0:HMAX-1];
  logic [W-1:0] swin [0:HMAX-1];
  logic         m_est = 1'b0, m_pend = 1'b0, m_need_rel = 1'b0, m_deliv = 1'b0;
  logic [W-1:0] m_saida = '0;
  logic         m_halt;

  function automatic logic bs_at(int e);
    bs_at = (e >= SYNC) ? bin[e-SYNC] : 1'b0;
  endfunction

  function automatic logic [W-1:0] sw_at(int e);
    sw_at = (e >= SYNC) ? swin[e-SYNC] : '0;
  endfunction

  function automatic logic m_flip(int e, logic est);
    m_flip = 1'b1;
    for (int j = 0; j < DEB; j++) if (bs_at(e - j) == est) m_flip = 1'b0;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      k <= 0; m_est <= 1'b0; m_pend <= 1'b0; m_need_rel <= 1'b0;
      m_deliv <= 1'b0; m_saida <= '0;
    end else begin
      bin[k]  <= botao;
      swin[k] <= switch;
      k       <= k + 1;
      if (m_flip(k, m_est)) m_est <= ~m_est;
      if (m_deliv) begin
        m_deliv <= 1'b0;
        m_pend  <= 1'b0;
      end else if (!m_pend) begin
        if (escreveInput) begin
          m_pend     <= 1'b1;
          m_need_rel <= m_est;
        end
      end else if (!escreveInput) begin
        m_pend <= 1'b0;
      end else if (m_need_rel) begin
        if (!m_est) m_need_rel <= 1'b0;
      end else if (m_est) begin
        m_deliv <= 1'b1;
        m_saida <= sw_at(k);
      end
    end
  end

  assign m_halt = reset_n & escreveInput & ~m_deliv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    chk("model_haltIn", 32'(haltIn), 32'(m_halt));
    chk("model_valido", 32'(valido), 32'(m_deliv));
    chk("model_saida", 32'(saida), 32'(m_saida));
    if (valido === 1'b1) n_deliv++;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk({tag, "_haltIn"}, 32'(haltIn), 32'd0);
    chk({tag, "_valido"}, 32'(valido), 32'd0);
    chk({tag, "_saida"}, 32'(saida), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Press now (between edges), expect silence for 6 edges and delivery on the 7th.
  task automatic press_expect(input string tag, input logic [W-1:0] val);
    botao = 1'b1;
    for (int i = 0; i < SYNC + DEB; i++) begin
      tick();
      chk({tag, "_early_valido"}, 32'(valido), 32'd0);
      chk({tag, "_early_haltIn"}, 32'(haltIn), 32'd1);
    end
    tick();
    chk({tag, "_valido"}, 32'(valido), 32'd1);
    chk({tag, "_haltIn"}, 32'(haltIn), 32'd0);
    chk({tag, "_saida"}, 32'(saida), 32'(val));
  endtask

  logic [W-1:0] v4, v5;
  int run;

  initial begin
    do_reset("reset_initial");

    // Clean press delivers the switch value seven edges after the press.
    escreveInput = 1'b1; switch = 18'h2A5F5;
    repeat (4) tick();
    chk("t2_halt_pending", 32'(haltIn), 32'd1);
    press_expect("t2", 18'h2A5F5);
    escreveInput = 1'b0;
    tick();
    chk("t2_pulse_end", 32'(valido), 32'd0);
    botao = 1'b0;
    repeat (10) tick();

    // Bouncing button never passes the debouncer.
    do_reset("reset_t3");
    escreveInput = 1'b1; switch = 18'h15A0C;
    repeat (3) tick();
    for (int p = 0; p < 5; p++) begin
      botao = 1'b1;
      repeat (2) begin tick(); chk("t3_bounce_valido", 32'(valido), 32'd0); end
      botao = 1'b0;
      repeat (2) begin tick(); chk("t3_bounce_valido", 32'(valido), 32'd0); end
    end
    press_expect("t3", 18'h15A0C);
    escreveInput = 1'b0; botao = 1'b0;
    repeat (10) tick();

    // Button already held at request: needs release and a new press.
    do_reset("reset_t4");
    botao = 1'b1;
    repeat (10) tick();
    v4 = W'($urandom);
    escreveInput = 1'b1; switch = v4;
    repeat (15) begin
      tick();
      chk("t4_held_haltIn", 32'(haltIn), 32'd1);
      chk("t4_held_valido", 32'(valido), 32'd0);
    end
    botao = 1'b0;
    repeat (10) begin
      tick();
      chk("t4_rel_haltIn", 32'(haltIn), 32'd1);
      chk("t4_rel_valido", 32'(valido), 32'd0);
    end
    press_expect("t4", v4);

    // Abort while waiting for a press: saida kept, later press ignored.
    escreveInput = 1'b0; botao = 1'b0;
    repeat (10) tick();
    escreveInput = 1'b1;
    repeat (5) tick();
    v5 = ~v4;
    switch = v5;
    escreveInput = 1'b0;
    tick();
    chk("t5_abort_haltIn", 32'(haltIn), 32'd0);
    botao = 1'b1;
    repeat (10) begin
      tick();
      chk("t5_abort_valido", 32'(valido), 32'd0);
      chk("t5_abort_saida", 32'(saida), 32'(v4));
    end
    botao = 1'b0;
    repeat (10) tick();

    // Back-to-back reads with escreveInput held high.
    escreveInput = 1'b1; switch = 18'h00001;
    repeat (4) tick();
    press_expect("t6_first", 18'h00001);
    botao = 1'b0; switch = 18'h3FFFF;
    repeat (12) begin
      tick();
      chk("t6_rearm_haltIn", 32'(haltIn), 32'd1);
      chk("t6_rearm_valido", 32'(valido), 32'd0);
    end
    press_expect("t6_second", 18'h3FFFF);
    escreveInput = 1'b0; botao = 1'b0;
    repeat (10) tick();

    // Random traffic against the model, with a reset dropped in mid-activity.
    do_reset("reset_rand");
    n_deliv = 0;
    run = 0;
    for (int i = 0; i < 2000; i++) begin
      if (run == 0) begin
        botao = 1'($urandom_range(0, 1));
        run   = $urandom_range(1, 9);
      end
      run--;
      if ($urandom_range(0, 24) == 0) escreveInput = ~escreveInput;
      if ($urandom_range(0, 7) == 0) switch = W'($urandom);
      if (i == 1000) do_reset("reset_mid");
      tick();
    end
    chk("rand_deliveries_seen", 32'(n_deliv > 0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
